// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: default address width and Gray/binary conversions.
// Used by both the read-side and write-side pointer controllers.
package fifo_pkg;

    localparam int DEF_ADDR_W = 3;
    localparam int FN_W       = 32;

    function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it
    function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
        logic [FN_W-1:0] b;
        b = '0;
        for (int i = 0; i < FN_W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_ptr_ctrl_if.sv
// Read-side pointer controller bus: read request, synchronised write pointer, flags.
// master = FIFO consumer side, slave = fifo_rd_ptr_ctrl.
interface fifo_rd_ptr_ctrl_if
    import fifo_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              rinc;
    logic [ADDR_W:0]   rq2_wptr;
    logic              runderflow_clr;
    logic [ADDR_W-1:0] raddr;
    logic [ADDR_W:0]   rptr_gray;
    logic              rempty;
    logic              ralmost_empty;
    logic [ADDR_W:0]   rlevel;
    logic              runderflow;

    modport master (
        output rinc, rq2_wptr, runderflow_clr,
        input  raddr, rptr_gray, rempty, ralmost_empty, rlevel, runderflow
    );

    modport slave (
        input  rinc, rq2_wptr, runderflow_clr,
        output raddr, rptr_gray, rempty, ralmost_empty, rlevel, runderflow
    );
endinterface

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter, width-parametrised; shared by read and write pointer logic.
// Zero latency, no backpressure.
module fifo_gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[W-1:i];
    end
endmodule

// File: rtl/fifo_rd_ptr_ctrl.sv
// Async-FIFO read pointer controller: binary/Gray read pointer, empty/almost-empty/level flags, 1-cycle registered.
// Reads while empty are dropped; optional sticky underflow flag under macro FIFO_RD_UNDERFLOW_EN.
module fifo_rd_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int AE_THRESH = 1
) (
    input  logic                rclk,
    input  logic                rrst_n,
    fifo_rd_ptr_ctrl_if.slave   rd_if
);
    localparam logic [ADDR_W:0] AE_T = (ADDR_W+1)'(AE_THRESH);

    logic [ADDR_W:0] r_bin;
    logic [ADDR_W:0] r_gray;
    logic            r_empty;
    logic            r_almost_empty;
    logic [ADDR_W:0] r_level;

    logic            w_fire;
    logic [ADDR_W:0] w_bin_next;
    logic [ADDR_W:0] w_gray_next;
    logic [ADDR_W:0] w_wbin;
    logic [ADDR_W:0] w_level_next;

    fifo_gray2bin #(.W(ADDR_W+1)) u_wptr_g2b (
        .i_gray (rd_if.rq2_wptr),
        .o_bin  (w_wbin)
    );

    assign w_fire       = rd_if.rinc & ~r_empty;
    assign w_bin_next   = r_bin + {{ADDR_W{1'b0}}, w_fire};
    assign w_gray_next  = w_bin_next ^ (w_bin_next >> 1);
    // Modulo subtraction keeps the level right across the pointer wrap
    assign w_level_next = w_wbin - w_bin_next;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_bin          <= '0;
            r_gray         <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_level        <= '0;
        end else begin
            r_bin          <= w_bin_next;
            r_gray         <= w_gray_next;
            r_empty        <= (w_gray_next == rd_if.rq2_wptr);
            r_almost_empty <= (w_level_next <= AE_T);
            r_level        <= w_level_next;
        end
    end

`ifdef FIFO_RD_UNDERFLOW_EN
    logic r_underflow;

    // Set has priority over a clear in the same cycle
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_underflow <= 1'b0;
        end else if (rd_if.rinc & r_empty) begin
            r_underflow <= 1'b1;
        end else if (rd_if.runderflow_clr) begin
            r_underflow <= 1'b0;
        end
    end

    assign rd_if.runderflow = r_underflow;
`else
    assign rd_if.runderflow = 1'b0;
`endif

    assign rd_if.raddr         = r_bin[ADDR_W-1:0];
    assign rd_if.rptr_gray     = r_gray;
    assign rd_if.rempty        = r_empty;
    assign rd_if.ralmost_empty = r_almost_empty;
    assign rd_if.rlevel        = r_level;

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// Bench for fifo_rd_ptr_ctrl: directed vector table, corner sequences, random traffic vs an occupancy model.
module tb_fifo_rd_ptr_ctrl;
    import fifo_pkg::*;

    localparam int AW = 3;
`ifdef FIFO_RD_UNDERFLOW_EN
    localparam bit UF_EN = 1'b1;
`else
    localparam bit UF_EN = 1'b0;
`endif

    logic rclk;
    logic rrst_n;

    fifo_rd_ptr_ctrl_if #(.ADDR_W(AW)) if1 ();
    fifo_rd_ptr_ctrl_if #(.ADDR_W(AW)) if4 ();

    assign if4.rinc           = if1.rinc;
    assign if4.rq2_wptr       = if1.rq2_wptr;
    assign if4.runderflow_clr = if1.runderflow_clr;

    fifo_rd_ptr_ctrl #(.ADDR_W(AW), .AE_THRESH(1)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .rd_if  (if1.slave)
    );

    fifo_rd_ptr_ctrl #(.ADDR_W(AW), .AE_THRESH(4)) dut4 (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .rd_if  (if4.slave)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: reads done so far (mod 16) and the occupancy they leave behind
    int m_rd, m_level;
    bit m_empty, m_uf;

    typedef struct {
        logic rinc;
        int   wbin;
        int   exp_raddr;
        int   exp_gray;
        int   exp_empty;
        int   exp_ae;
        int   exp_level;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic ri, int w, int ra, int g, int e, int ae, int lv);
        vec_t v;
        v.rinc = ri; v.wbin = w; v.exp_raddr = ra; v.exp_gray = g;
        v.exp_empty = e; v.exp_ae = ae; v.exp_level = lv;
        return v;
    endfunction

    function automatic logic [AW:0] to_gray(int b);
        int bb;
        bb = b % 16;
        return (AW+1)'(bb ^ (bb / 2));
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rd = 0; m_level = 0; m_empty = 1'b1; m_uf = 1'b0;
    endtask

    task automatic check_model();
        check("m_raddr", 32'(if1.raddr), 32'(m_rd % 8));
        check("m_gray",  32'(if1.rptr_gray), 32'(to_gray(m_rd)));
        check("m_empty", 32'(if1.rempty), 32'(m_empty));
        check("m_level", 32'(if1.rlevel), 32'(m_level));
        check("m_ae1",   32'(if1.ralmost_empty), 32'(m_level <= 1));
        check("m_ae4",   32'(if4.ralmost_empty), 32'(m_level <= 4));
        check("m_lvl4",  32'(if4.rlevel), 32'(m_level));
        check("m_uf",    32'(if1.runderflow), 32'(m_uf));
    endtask

    // Drive one cycle, advance the model on the edge, then compare 1 time unit later
    task automatic step(input logic ri, input int wbin, input logic clr);
        bit fire;
        if1.rinc           = ri;
        if1.rq2_wptr       = to_gray(wbin);
        if1.runderflow_clr = clr;
        @(posedge rclk);
        fire = ri && !m_empty;
        if (UF_EN) begin
            if (ri && m_empty) m_uf = 1'b1;
            else if (clr)      m_uf = 1'b0;
        end
        m_rd    = (m_rd + int'(fire)) % 16;
        m_level = (wbin - m_rd + 32) % 16;
        m_empty = (m_level == 0);
        #1;
        check_model();
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_raddr"}, 32'(if1.raddr), 0);
        check({tag, "_gray"},  32'(if1.rptr_gray), 0);
        check({tag, "_empty"}, 32'(if1.rempty), 1);
        check({tag, "_ae"},    32'(if1.ralmost_empty), 1);
        check({tag, "_level"}, 32'(if1.rlevel), 0);
        check({tag, "_uf"},    32'(if1.runderflow), 0);
    endtask

    initial begin
        int w;
        // Fill/drain, wrap, simultaneous read + write advance, read while empty
        vecs[0]  = mk(0, 3,  0, 4'b0000, 0, 0, 3);
        vecs[1]  = mk(1, 3,  1, 4'b0001, 0, 0, 2);
        vecs[2]  = mk(1, 3,  2, 4'b0011, 0, 1, 1);
        vecs[3]  = mk(1, 3,  3, 4'b0010, 1, 1, 0);
        vecs[4]  = mk(0, 7,  3, 4'b0010, 0, 0, 4);
        vecs[5]  = mk(1, 7,  4, 4'b0110, 0, 0, 3);
        vecs[6]  = mk(1, 7,  5, 4'b0111, 0, 0, 2);
        vecs[7]  = mk(1, 7,  6, 4'b0101, 0, 1, 1);
        vecs[8]  = mk(1, 7,  7, 4'b0100, 1, 1, 0);
        vecs[9]  = mk(0, 9,  7, 4'b0100, 0, 0, 2);
        vecs[10] = mk(1, 9,  0, 4'b1100, 0, 1, 1);
        vecs[11] = mk(1, 9,  1, 4'b1101, 1, 1, 0);
        vecs[12] = mk(0, 10, 1, 4'b1101, 0, 1, 1);
        vecs[13] = mk(1, 11, 2, 4'b1111, 0, 1, 1);
        vecs[14] = mk(1, 11, 3, 4'b1110, 1, 1, 0);
        vecs[15] = mk(1, 11, 3, 4'b1110, 1, 1, 0);

        if1.rinc = 1'b0; if1.rq2_wptr = '0; if1.runderflow_clr = 1'b0;
        rrst_n = 1'b1;
        model_reset();
        #2 rrst_n = 1'b0;
        #1 check_reset_vals("rst0");
        repeat (2) @(posedge rclk);
        @(negedge rclk);
        rrst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].rinc, vecs[i].wbin, 1'b0);
            check($sformatf("v%0d_raddr", i), 32'(if1.raddr), 32'(vecs[i].exp_raddr));
            check($sformatf("v%0d_gray", i),  32'(if1.rptr_gray), 32'(vecs[i].exp_gray));
            check($sformatf("v%0d_empty", i), 32'(if1.rempty), 32'(vecs[i].exp_empty));
            check($sformatf("v%0d_ae", i),    32'(if1.ralmost_empty), 32'(vecs[i].exp_ae));
            check($sformatf("v%0d_level", i), 32'(if1.rlevel), 32'(vecs[i].exp_level));
        end

        // Underflow: vector 15 was a read while empty
        check("uf_set", 32'(if1.runderflow), 32'(UF_EN));
        step(1'b0, 11, 1'b1);
        check("uf_clr", 32'(if1.runderflow), 0);
        step(1'b1, 11, 1'b1);
        check("uf_set_wins", 32'(if1.runderflow), 32'(UF_EN));
        check("uf_raddr_hold", 32'(if1.raddr), 3);
        step(1'b0, 11, 1'b0);
        check("uf_sticky", 32'(if1.runderflow), 32'(UF_EN));

        // Random traffic; writer never overfills (level stays <= 8)
        w = 11;
        for (int c = 0; c < 400; c++) begin
            if (((w - m_rd + 32) % 16) < 8 && $urandom_range(0, 2) != 0) w = (w + 1) % 16;
            step(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 7) == 0));
        end

        // Reset in the middle of a burst, between clock edges
        w = (m_rd + 5) % 16;
        step(1'b0, w, 1'b0);
        step(1'b1, w, 1'b0);
        #2 rrst_n = 1'b0;
        #1 check_reset_vals("rst_mid");
        model_reset();
        @(negedge rclk);
        rrst_n = 1'b1;

        // Almost-empty at threshold 4
        step(1'b0, 6, 1'b0);
        check("ae4_l6", 32'(if4.ralmost_empty), 0);
        check("ae4_lvl6", 32'(if4.rlevel), 6);
        step(1'b1, 6, 1'b0);
        check("ae4_l5", 32'(if4.ralmost_empty), 0);
        step(1'b1, 6, 1'b0);
        check("ae4_l4", 32'(if4.ralmost_empty), 1);
        check("ae4_lvl4", 32'(if4.rlevel), 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
